// File: rtl/rv_ahb_sram.sv
// AHB-style single-port SRAM slave with pipelined address/data phases,
// programmable wait states, write-to-read forwarding and out-of-window error pulse.
module rv_ahb_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ABus,
  input  logic [1:0]  TRANSBus,
  input  logic        WRITEBus,
  input  logic [31:0] WDBus,
  output logic [31:0] RDBus,
  output logic        RDYBus,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          r_pend;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_wr;
  logic          r_hit;
  logic          r_err;
  logic [31:0]   r_rd;

  logic          w_rdy;
  logic          w_accept;
  logic          w_complete;
  logic          w_hit;
  logic          w_wr_en;
  logic [AW-1:0] w_idx;
  logic [2:0]    w_unused;

  assign w_unused   = {ABus[1:0], TRANSBus[0]};
  assign w_idx      = ABus[AW+1:2];
  assign w_hit      = (ABus[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_rdy      = !r_pend || (r_cnt == 4'd0);
  assign w_accept   = w_rdy && TRANSBus[1];
  assign w_complete = r_pend && w_rdy;
  // Reset wins over a completing write so an abandoned transfer never lands.
  assign w_wr_en    = rst_n && w_complete && r_wr && r_hit;

  assign RDYBus = w_rdy;
  assign err    = r_err;
  assign RDBus  = (r_pend && !r_wr && r_hit) ? r_rd : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_accept && !w_hit;
      if (w_accept) begin
        r_pend <= 1'b1;
        r_cnt  <= 4'(WAIT_STATES);
        r_wr   <= WRITEBus;
        r_addr <= w_idx;
        r_hit  <= w_hit;
      end else if (w_complete) begin
        r_pend <= 1'b0;
      end else if (r_pend && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_addr] <= WDBus;
    end
    if (w_accept) begin
      // A write completing on this edge to the same word is forwarded.
      if (w_wr_en && (r_addr == w_idx)) begin
        r_rd <= WDBus;
      end else begin
        r_rd <= r_mem[w_idx];
      end
    end
  end

endmodule
